mnist_seq_ctrl: RTL and testbench

Run sequencer for the MNIST inference accelerator. On a `start` pulse from the picoRV32 side it:
- clears the accumulators;
- streams pixel addresses 0..783 to the image memory while enabling accumulation;
- waits for the datapath pipeline to drain;
- scans the ten class scores through a select mux to find the signed maximum.

It then reports the winning class and its score with a one-cycle `done` pulse. It sits between the CPU bus interface and the accelerator datapath/image memory, replacing the free-running pixel counter.

---
 rtl/mnist_seq_ctrl_if.sv | 31 +++
 rtl/mnist_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_mnist_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_seq_ctrl_if.sv
// mnist_seq_ctrl_if: bundle between the run sequencer and its CPU/datapath neighbours.
//   master : sequencer side (drives control, address, select and result outputs)
//   slave  : environment side (drives start/abort and the selected class score)
// Signals: start, abort, busy, done, acc_clear, acc_en, pix_addr[AW], result_sel[4],
//          result_in[32] (signed score selected by result_sel), class_out[4], max_score[32]
`timescale 1ns/1ps
interface mnist_seq_ctrl_if #(
   parameter int unsigned AW = 10
);
   logic          start;
   logic          abort;
   logic          busy;
   logic          done;
   logic          acc_clear;
   logic          acc_en;
   logic [AW-1:0] pix_addr;
   logic [3:0]    result_sel;
   logic [31:0]   result_in;
   logic [3:0]    class_out;
   logic [31:0]   max_score;

   modport master (
      input  start, abort, result_in,
      output busy, done, acc_clear, acc_en, pix_addr, result_sel, class_out, max_score
   );

   modport slave (
      output start, abort, result_in,
      input  busy, done, acc_clear, acc_en, pix_addr, result_sel, class_out, max_score
   );
endinterface

// File: rtl/mnist_seq_ctrl.sv
// mnist_seq_ctrl: run sequencer for the MNIST inference accelerator.
// A start request in IDLE clears the accumulators, streams pixel addresses 0..NPIX-1 with
// accumulation enabled, waits DRAIN cycles for the datapath to settle, then scans the NCLASS
// scores for the signed maximum (ties keep the lowest index) and pulses done for one cycle.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high, clears all state
//   bus   - mnist_seq_ctrl_if.master (start/abort in, control/address/result out)
// Build option: define MNIST_SEQ_ABORT_EN to let abort cancel a run in progress; otherwise
// abort is ignored and a started run always completes unless reset.
`timescale 1ns/1ps
module mnist_seq_ctrl #(
   parameter int unsigned NPIX   = 784,
   parameter int unsigned NCLASS = 10,
   parameter int unsigned DRAIN  = 4,
   parameter int unsigned AW     = 10
) (
   input  logic             clk,
   input  logic             reset,
   mnist_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StScan,
      StDone
   } state_e;

   state_e             state_q, state_d;
   // One counter serves pixel address, drain wait and score select; it is 0 on entry to each.
   logic [AW-1:0]      cnt_q, cnt_d;
   logic signed [31:0] run_max_q, run_max_d;
   logic [3:0]         run_idx_q, run_idx_d;
   logic [3:0]         class_q, class_d;
   logic signed [31:0] score_q, score_d;

   logic               abort_hit;
   logic               take;
   logic [3:0]         sel;

`ifdef MNIST_SEQ_ABORT_EN
   assign abort_hit = bus.abort & (state_q != StIdle);
`else
   logic unused_abort;
   assign unused_abort = bus.abort;
   assign abort_hit    = 1'b0;
`endif

   assign sel  = (state_q == StScan) ? cnt_q[3:0] : 4'd0;
   // Entry 0 always loads the running max; later entries must be strictly greater.
   assign take = (sel == 4'd0) || ($signed(bus.result_in) > run_max_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_max_d = run_max_q;
      run_idx_d = run_idx_q;
      class_d   = class_q;
      score_d   = score_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StClear;
            end
         end
         StClear: begin
            state_d = StFeed;
            cnt_d   = '0;
         end
         StFeed: begin
            if (cnt_q == AW'(NPIX - 1)) begin
               state_d = StDrain;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         StDrain: begin
            if (cnt_q == AW'(DRAIN - 1)) begin
               state_d = StScan;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         StScan: begin
            if (take) begin
               run_max_d = $signed(bus.result_in);
               run_idx_d = sel;
            end
            if (cnt_q == AW'(NCLASS - 1)) begin
               // Publish including the final entry so results are visible during DONE.
               state_d = StDone;
               cnt_d   = '0;
               class_d = run_idx_d;
               score_d = run_max_d;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Cancellation discards the run without touching the published result.
      if (abort_hit) begin
         state_d = StIdle;
         cnt_d   = '0;
         class_d = class_q;
         score_d = score_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         run_max_q <= '0;
         run_idx_q <= '0;
         class_q   <= '0;
         score_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_max_q <= run_max_d;
         run_idx_q <= run_idx_d;
         class_q   <= class_d;
         score_q   <= score_d;
      end
   end

   assign bus.busy       = (state_q != StIdle);
   assign bus.done       = (state_q == StDone);
   assign bus.acc_clear  = (state_q == StClear) & ~abort_hit;
   assign bus.acc_en     = (state_q == StFeed) & ~abort_hit;
   assign bus.pix_addr   = (state_q == StFeed) ? cnt_q : '0;
   assign bus.result_sel = sel;
   assign bus.class_out  = class_q;
   assign bus.max_score  = score_q;

endmodule

// File: tb/tb_mnist_seq_ctrl.sv
// Bench for mnist_seq_ctrl: a cycle-phase reference checks every control output each cycle;
// expected argmax results are queued when a run is launched and compared on each done pulse.
`timescale 1ns/1ps
module tb_mnist_seq_ctrl;
   localparam int NPIX    = 784;
   localparam int NCLASS  = 10;
   localparam int DRAIN   = 4;
   localparam int AW      = 10;
   localparam int DonePh  = NPIX + DRAIN + NCLASS + 2;
   localparam int ScanPh  = NPIX + DRAIN + 2;
`ifdef MNIST_SEQ_ABORT_EN
   localparam bit AbortEn = 1'b1;
`else
   localparam bit AbortEn = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  cls;
      logic [31:0] score;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] scores [16];
   exp_t        sb_q [$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   int          ph       = 0;
   int          sv [10];

   mnist_seq_ctrl_if #(.AW(AW)) bus ();

   mnist_seq_ctrl #(
      .NPIX  (NPIX),
      .NCLASS(NCLASS),
      .DRAIN (DRAIN),
      .AW    (AW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   assign bus.result_in = scores[bus.result_sel];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t argmax();
      exp_t e;
      e.cls   = 4'd0;
      e.score = scores[0];
      for (int i = 1; i < NCLASS; i++) begin
         if ($signed(scores[i]) > $signed(e.score)) begin
            e.cls   = 4'(i);
            e.score = scores[i];
         end
      end
      return e;
   endfunction

   task automatic load_scores();
      for (int i = 0; i < 16; i++) begin
         scores[i] = (i < NCLASS) ? 32'(sv[i]) : 32'd0;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int  prev;
      bit  seen;
      prev = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done_cnt != prev) seen = 1'b1;
      end
      if (!seen) check_eq("done_timeout", 32'(done_cnt), 32'(prev + 1));
   endtask

   // Reference: ph is the cycle number within a run (0 = idle), derived from the run timeline.
   logic        ab;
   logic        feed;
   logic [17:0] exp_ctl, obs_ctl;
   logic [AW-1:0] exp_pix;
   logic [3:0]  exp_sel;
   exp_t        e_pop;

   always @(negedge clk) begin
      ab      = AbortEn && (bus.abort === 1'b1) && (ph != 0);
      feed    = (ph >= 2) && (ph <= NPIX + 1);
      exp_pix = feed ? AW'(ph - 2) : '0;
      exp_sel = (ph >= ScanPh && ph < DonePh) ? 4'(ph - ScanPh) : 4'd0;
      exp_ctl = {ph != 0, ph == DonePh, (ph == 1) && !ab, feed && !ab, exp_pix, exp_sel};
      obs_ctl = {bus.busy, bus.done, bus.acc_clear, bus.acc_en, bus.pix_addr, bus.result_sel};
      check_eq("ctl", 32'(obs_ctl), 32'(exp_ctl));

      if (bus.done === 1'b1) begin
         done_cnt++;
         check_eq("sb_pending", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e_pop = sb_q.pop_front();
            check_eq("class_out", 32'(bus.class_out), 32'(e_pop.cls));
            check_eq("max_score", bus.max_score, e_pop.score);
         end
      end

      if (reset) ph = 0;
      else if (ab) ph = 0;
      else if (ph == 0) ph = (bus.start === 1'b1) ? 1 : 0;
      else if (ph == DonePh) ph = 0;
      else ph = ph + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) scores[i] = 32'd0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      reset     = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(20);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);
      check_eq("idle_class", 32'(bus.class_out), 32'd0);
      check_eq("idle_score", bus.max_score, 32'd0);

      // Run 1: tie between indices 2 and 3; start re-pulsed mid-run must be ignored.
      sv = '{5, -3, 9, 9, 0, 0, 0, 0, 0, -1};
      load_scores();
      sb_q.push_back(argmax());
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(399);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      wait_done(500);
      check_eq("r1_class", 32'(bus.class_out), 32'd2);
      check_eq("r1_score", bus.max_score, 32'd9);
      tick(20);

      // Run 2: all negative, start held high to chain a second run with extreme scores.
      sv = '{-8, -2, -7, -9, -3, -5, -100, -2, -4, -6};
      load_scores();
      sb_q.push_back(argmax());
      bus.start = 1'b1;
      wait_done(900);
      check_eq("neg_class", 32'(bus.class_out), 32'd1);
      check_eq("neg_score", bus.max_score, 32'hFFFF_FFFE);
      sv = '{int'(32'h8000_0000), -1, 0, 5, 5, 0, 0, 0, 1, 2147483647};
      load_scores();
      sb_q.push_back(argmax());
      tick(1);
      bus.start = 1'b0;
      wait_done(900);
      check_eq("ext_class", 32'(bus.class_out), 32'd9);
      check_eq("ext_score", bus.max_score, 32'h7FFF_FFFF);
      tick(10);

      // Run 3: reset in cycle 300 discards the run and clears the result.
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(299);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_acc_en", 32'(bus.acc_en), 32'd0);
      check_eq("rst_pix", 32'(bus.pix_addr), 32'd0);
      check_eq("rst_class", 32'(bus.class_out), 32'd0);
      check_eq("rst_score", bus.max_score, 32'd0);
      tick(20);

      // Run 4: a completed run, then a run with abort raised in cycle 790.
      sv = '{5, -3, 9, 9, 0, 0, 0, 0, 0, -1};
      load_scores();
      sb_q.push_back(argmax());
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      wait_done(900);
      tick(5);
      sv = '{0, 0, 0, 0, 0, 100, 0, 0, 0, 0};
      load_scores();
`ifndef MNIST_SEQ_ABORT_EN
      sb_q.push_back(argmax());
`endif
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(789);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
`ifdef MNIST_SEQ_ABORT_EN
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      tick(20);
      check_eq("abort_class", 32'(bus.class_out), 32'd2);
      check_eq("abort_score", bus.max_score, 32'd9);
`else
      wait_done(100);
      check_eq("noabort_class", 32'(bus.class_out), 32'd5);
      check_eq("noabort_score", bus.max_score, 32'd100);
`endif
      tick(10);
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
